// File: rtl/write_responder.sv
// write_responder: two-state write handshake responder.
//   A start strobe (do_wr_i in IDLE) captures wr_valid_i/wr_data_i and the minimum hold time.
//   The responder holds ready_o high until the writer sends a completion strobe after at least
//   min_q ready cycles, or it aborts after TIMEOUT ready cycles.
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   do_wr_i                start strobe (IDLE) / completion strobe (HOLD)
//   wr_valid_i, wr_data_i  writer flag and data
//   cfg_min_hold_i         minimum ready cycles before completion (0 acts as 1)
//   ready_o, busy_o        registered ready, non-idle indicator
//   done_o, mismatch_o     completion pulse and flag-mismatch pulse
//   timeout_o              abort pulse
//   rd_data_o, wr_count_o  captured data, completed-transaction count
module write_responder #(
  parameter int unsigned DATA_W  = 8,
  parameter int unsigned HOLD_W  = 4,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              do_wr_i,
  input  logic              wr_valid_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [HOLD_W-1:0] cfg_min_hold_i,
  output logic              ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              mismatch_o,
  output logic              timeout_o,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [15:0]       wr_count_o
);

  typedef enum logic [0:0] {StIdle, StHold} state_e;

  state_e              state_q, state_d;
  logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
  logic [HOLD_W-1:0]   min_q, min_d;
  logic                was_valid_q, was_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic [15:0]         wr_count_q, wr_count_d;
  logic                ready_q, ready_d;
  logic                done_q, done_d;
  logic                mismatch_q, mismatch_d;
  logic                timeout_q, timeout_d;
  logic                start, accept, abort;

  // State register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic. Completion wins over a coincident timeout.
  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    accept  = 1'b0;
    abort   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (do_wr_i) begin
          start   = 1'b1;
          state_d = StHold;
        end
      end
      StHold: begin
        if (do_wr_i && (hold_cnt_q >= min_q)) begin
          accept  = 1'b1;
          state_d = StIdle;
        end else if (hold_cnt_q == HOLD_W'(TIMEOUT - 1)) begin
          abort   = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output and datapath next values; all outputs are registered.
  always_comb begin
    hold_cnt_d  = '0;
    min_d       = min_q;
    was_valid_d = was_valid_q;
    rd_data_d   = rd_data_q;
    wr_count_d  = wr_count_q;
    ready_d     = (state_d == StHold);
    done_d      = accept;
    mismatch_d  = accept && (wr_valid_i != was_valid_q);
    timeout_d   = abort;
    if (start) begin
      was_valid_d = wr_valid_i;
      rd_data_d   = wr_data_i;
      min_d       = (cfg_min_hold_i == '0) ? HOLD_W'(1) : cfg_min_hold_i;
    end
    if ((state_q == StHold) && (state_d == StHold)) begin
      hold_cnt_d = hold_cnt_q + HOLD_W'(1);
    end
    if (accept) begin
      wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hold_cnt_q  <= '0;
      min_q       <= HOLD_W'(1);
      was_valid_q <= 1'b0;
      rd_data_q   <= '0;
      wr_count_q  <= '0;
      ready_q     <= 1'b0;
      done_q      <= 1'b0;
      mismatch_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      hold_cnt_q  <= hold_cnt_d;
      min_q       <= min_d;
      was_valid_q <= was_valid_d;
      rd_data_q   <= rd_data_d;
      wr_count_q  <= wr_count_d;
      ready_q     <= ready_d;
      done_q      <= done_d;
      mismatch_q  <= mismatch_d;
      timeout_q   <= timeout_d;
    end
  end

  assign ready_o    = ready_q;
  assign busy_o     = (state_q != StIdle);
  assign done_o     = done_q;
  assign mismatch_o = mismatch_q;
  assign timeout_o  = timeout_q;
  assign rd_data_o  = rd_data_q;
  assign wr_count_o = wr_count_q;

endmodule
